ofmap_drain: RTL and testbench
==============================

Name: ofmap_drain

Overview:
Downstream drain stage for the Systolic array. Triggered by the array's finish pulse, it walks every OFMAP row address through the array's test read port (test_output_addr_in / test_check_in / test_output_out). It captures each MAC_COL-wide row and serializes it lane by lane onto a valid/ready stream of OFMAP_BITWIDTH words. The stream feeds the writeback/DMA path.

Parameters:
MAC_COL, 16, lanes per OFMAP row
OFMAP_BITWIDTH, 32, bits per lane/output word
OFMAP_ADDR_BIT, 10, OFMAP row address width
OFMAP_NUM, 784, rows to drain; must satisfy 1 <= OFMAP_NUM <= 2^OFMAP_ADDR_BIT

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start_in  in  1  one-cycle start pulse; driven by Systolic finish_out
rd_addr_out  out  OFMAP_ADDR_BIT  row address; connects to test_output_addr_in
rd_en_out  out  1  read strobe; connects to test_check_in
rd_data_in  in  MAC_COL*OFMAP_BITWIDTH  row data; connects to test_output_out; valid exactly 1 cycle after rd_en_out
m_valid_out  out  1  stream word valid
m_ready_in  in  1  stream consumer ready
m_data_out  out  OFMAP_BITWIDTH  stream word
m_last_out  out  1  final word of final row
busy_out  out  1  drain in progress
done_out  out  1  one-cycle pulse after last word accepted

Behaviour:
- Reset: asynchronous on rstn low; FSM=IDLE; row_idx=0, lane=0, row buffer=0; all outputs 0. Reset mid-drain aborts immediately; no done_out is produced.
- FSM states: IDLE, REQ, LAT, STREAM, DONE. All outputs are registered or decoded from state only; there is no combinational path from m_ready_in to m_valid_out.
- IDLE: busy_out=0. start_in=1 -> row_idx=0 -> REQ. start_in is ignored in every other state.
- REQ (1 cycle): rd_en_out=1, rd_addr_out=row_idx -> LAT.
- LAT (1 cycle): rd_en_out=0. Row buffer <= rd_data_in at the end of the cycle; lane=0 -> STREAM.
- STREAM:
  - m_valid_out=1; m_data_out = buffer[OFMAP_BITWIDTH*(lane+1)-1 : OFMAP_BITWIDTH*lane]. Lane 0 is the LSB slice.
  - Handshake occurs when m_valid_out && m_ready_in. On handshake with lane < MAC_COL-1: lane++.
  - On handshake with lane==MAC_COL-1: if row_idx==OFMAP_NUM-1 -> DONE; else row_idx++ -> REQ.
  - m_valid_out && !m_ready_in: m_data_out and m_last_out hold stable. Valid never drops before handshake.
  - m_last_out=1 only when lane==MAC_COL-1 && row_idx==OFMAP_NUM-1.
- DONE (1 cycle): done_out=1, m_valid_out=0 -> IDLE.
- busy_out=1 in REQ, LAT, STREAM and DONE.
- rd_addr_out holds its last value outside REQ.
- Timing: start_in to first m_valid_out is 3 cycles. With m_ready_in tied high, each row takes MAC_COL+2 cycles. Total drain is OFMAP_NUM*(MAC_COL+2)+1 cycles from REQ to done_out.
- Widths: row_idx is OFMAP_ADDR_BIT bits and never wraps (stops at OFMAP_NUM-1). lane is $clog2(MAC_COL) bits, minimum 1.

Optional Feature:
OFMAP_DRAIN_RELU_EN
- Defined: m_data_out is ReLU-applied. If the word's MSB is 1 (signed negative), output 0; otherwise output the word unchanged. The row buffer keeps raw data.
- Undefined: m_data_out is the raw lane slice. No other behaviour changes in either case.

Test Plan:
- Basic, OFMAP_NUM=4, MAC_COL=4, m_ready_in=1, row r lane l = r*16+l:
  - start_in pulse -> rd_addr_out 0,1,2,3 each with a 1-cycle rd_en_out.
  - 16 words 0x00..0x03, 0x10..0x13, ..., 0x30..0x33 in order.
  - m_last_out only on 0x33; done_out 1 cycle later; 25 cycles REQ-to-done.
- Backpressure: m_ready_in toggles 1,0,0,1 repeating -> identical word sequence; m_data_out stable while stalled; no word lost or duplicated.
- Full size, default parameters, data from ofmap.hex -> 784*16 words match file rows LSB-lane-first; done_out at cycle 14113 after REQ.
- start_in while busy: pulse at a mid-stream row -> sequence unaffected; exactly one done_out.
- Reset mid-drain: rstn low during row 2 lane 1 -> all outputs 0 asynchronously. A new start_in after release restarts from row 0.
- RELU_EN defined: lane values 0xFFFFFFFF, 0x7FFFFFFF, 0x80000000, 0x00000005 -> 0, 0x7FFFFFFF, 0, 5; undefined -> raw values.

Source files
------------

// File: rtl/ofmap_drain.sv
// Drains every OFMAP row of the systolic array via its test read port and serializes it onto a valid/ready stream.
// Define OFMAP_DRAIN_RELU_EN to apply ReLU to streamed words (the row buffer always keeps raw data).
module ofmap_drain #(
    parameter int MAC_COL        = 16,
    parameter int OFMAP_BITWIDTH = 32,
    parameter int OFMAP_ADDR_BIT = 10,
    parameter int OFMAP_NUM      = 784
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start_in,
    output logic [OFMAP_ADDR_BIT-1:0]         rd_addr_out,
    output logic                              rd_en_out,
    input  logic [MAC_COL*OFMAP_BITWIDTH-1:0] rd_data_in,
    output logic                              m_valid_out,
    input  logic                              m_ready_in,
    output logic [OFMAP_BITWIDTH-1:0]         m_data_out,
    output logic                              m_last_out,
    output logic                              busy_out,
    output logic                              done_out
);

    localparam int LANE_W = (MAC_COL > 1) ? $clog2(MAC_COL) : 1;
    localparam logic [OFMAP_ADDR_BIT-1:0] LAST_ROW  = OFMAP_ADDR_BIT'(OFMAP_NUM - 1);
    localparam logic [LANE_W-1:0]         LAST_LANE = LANE_W'(MAC_COL - 1);

    typedef enum logic [2:0] {IDLE, REQ, LAT, STREAM, DONE} state_t;

    state_t                            state;
    state_t                            state_nxt;
    logic [OFMAP_ADDR_BIT-1:0]         row_idx;
    logic [LANE_W-1:0]                 lane;
    logic [MAC_COL*OFMAP_BITWIDTH-1:0] row_buf;
    logic [OFMAP_BITWIDTH-1:0]         lane_word;
    logic                              handshake;
    logic                              last_lane;
    logic                              last_row;

    assign handshake = (state == STREAM) && m_ready_in;
    assign last_lane = (lane == LAST_LANE);
    assign last_row  = (row_idx == LAST_ROW);
    assign lane_word = row_buf[int'(lane)*OFMAP_BITWIDTH +: OFMAP_BITWIDTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_in) state_nxt = REQ;
            REQ:     state_nxt = LAT;
            LAT:     state_nxt = STREAM;
            STREAM:  if (handshake && last_lane) state_nxt = last_row ? DONE : REQ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // row_idx only moves on entry to REQ, so it doubles as the held read address
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_idx <= '0;
            lane    <= '0;
            row_buf <= '0;
        end else begin
            if (state == IDLE && start_in) begin
                row_idx <= '0;
            end
            if (state == LAT) begin
                row_buf <= rd_data_in;
                lane    <= '0;
            end
            if (handshake) begin
                if (!last_lane) begin
                    lane <= lane + LANE_W'(1);
                end else if (!last_row) begin
                    row_idx <= row_idx + OFMAP_ADDR_BIT'(1);
                end
            end
        end
    end

    always_comb begin
        rd_en_out   = (state == REQ);
        rd_addr_out = row_idx;
        m_valid_out = (state == STREAM);
        m_last_out  = (state == STREAM) && last_lane && last_row;
        busy_out    = (state != IDLE);
        done_out    = (state == DONE);
`ifdef OFMAP_DRAIN_RELU_EN
        m_data_out  = lane_word[OFMAP_BITWIDTH-1] ? '0 : lane_word;
`else
        m_data_out  = lane_word;
`endif
    end

endmodule

// File: tb/tb_ofmap_drain.sv
// Self-checking bench for ofmap_drain: scenario table, ReLU table, reset-abort sequence,
// all checked against a row/lane reference model of the drained stream.
module tb_ofmap_drain;

    localparam int MC  = 4;
    localparam int W   = 32;
    localparam int AB  = 2;
    localparam int NUM = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start_in;
    logic [AB-1:0]     rd_addr_out;
    logic              rd_en_out;
    logic [MC*W-1:0]   rd_data_in;
    logic              m_valid_out;
    logic              m_ready_in;
    logic [W-1:0]      m_data_out;
    logic              m_last_out;
    logic              busy_out;
    logic              done_out;

    ofmap_drain #(
        .MAC_COL(MC), .OFMAP_BITWIDTH(W), .OFMAP_ADDR_BIT(AB), .OFMAP_NUM(NUM)
    ) dut (
        .clk(clk), .rstn(rstn), .start_in(start_in),
        .rd_addr_out(rd_addr_out), .rd_en_out(rd_en_out), .rd_data_in(rd_data_in),
        .m_valid_out(m_valid_out), .m_ready_in(m_ready_in), .m_data_out(m_data_out),
        .m_last_out(m_last_out), .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clk = ~clk;

    // Array test-port model: row data appears one cycle after the read strobe
    logic [W-1:0] mem [NUM][MC];
    always @(posedge clk) begin
        if (rd_en_out) begin
            for (int l = 0; l < MC; l++) rd_data_in[l*W +: W] <= mem[rd_addr_out][l];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int           addr_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_word(input logic [W-1:0] v);
`ifdef OFMAP_DRAIN_RELU_EN
        return v[W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic fill_mem(input bit rnd);
        for (int r = 0; r < NUM; r++)
            for (int l = 0; l < MC; l++)
                mem[r][l] = rnd ? W'($urandom) : W'(r*16 + l);
    endtask

    task automatic build_exp();
        exp_q.delete();
        addr_q.delete();
        for (int r = 0; r < NUM; r++) begin
            addr_q.push_back(r);
            for (int l = 0; l < MC; l++) exp_q.push_back(ref_word(mem[r][l]));
        end
    endtask

    // mode 0: ready high, 1: 1,0,0,1 repeating, 2: random
    task automatic run_drain(input int mode, input bit mid_start, input int exp_cycles);
        int pat[4] = '{1, 0, 0, 1};
        int cycles = 0;
        int first_valid = 0;
        bit done_seen = 0;
        bit prev_stall = 0;
        logic [W-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        @(negedge clk); start_in = 1'b1;
        @(negedge clk); start_in = 1'b0;
        while (!done_seen && cycles < 2000) begin
            cycles++;
            case (mode)
                0:       m_ready_in = 1'b1;
                1:       m_ready_in = pat[(cycles-1) % 4][0];
                default: m_ready_in = 1'($urandom_range(0, 1));
            endcase
            if (rd_en_out) begin
                check("rd_addr", rd_addr_out, (addr_q.size() > 0) ? addr_q[0] : -1);
                if (addr_q.size() > 0) void'(addr_q.pop_front());
            end
            if (prev_stall) begin
                check("stall_valid", m_valid_out, 1);
                check("stall_data", m_data_out, prev_data);
                check("stall_last", m_last_out, prev_last);
            end
            prev_stall = 0;
            if (m_valid_out) begin
                if (first_valid == 0) first_valid = cycles;
                if (m_ready_in) begin
                    check("word", m_data_out, (exp_q.size() > 0) ? exp_q[0] : 'x);
                    check("last", m_last_out, exp_q.size() == 1);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else begin
                    prev_stall = 1;
                    prev_data  = m_data_out;
                    prev_last  = m_last_out;
                end
            end
            if (done_out) begin
                done_seen = 1;
                check("done_words_left", exp_q.size(), 0);
                check("done_reads_left", addr_q.size(), 0);
                check("done_busy", busy_out, 1);
                check("done_valid", m_valid_out, 0);
                if (exp_cycles > 0) check("drain_cycles", cycles, exp_cycles);
            end
            start_in = (mid_start && cycles == 10);
            @(negedge clk);
        end
        start_in = 1'b0;
        check("done_seen", done_seen, 1);
        check("first_valid_latency", first_valid, 3);
        check("post_done_pulse", done_out, 0);
        check("post_done_busy", busy_out, 0);
        repeat (3) @(negedge clk);
        check("no_restart", busy_out, 0);
        m_ready_in = 1'b0;
    endtask

    typedef struct {
        int mode;
        bit mid_start;
        bit rnd;
        int exp_cycles;
    } scen_t;

    typedef struct {
        logic [W-1:0] raw;
        logic [W-1:0] expect_out;
    } relu_t;

    initial begin
        scen_t sc[5];
        relu_t rt[MC];
        sc[0] = '{0, 1'b0, 1'b0, NUM*(MC+2)+1};
        sc[1] = '{1, 1'b0, 1'b0, 0};
        sc[2] = '{0, 1'b1, 1'b1, NUM*(MC+2)+1};
        sc[3] = '{2, 1'b0, 1'b1, 0};
        sc[4] = '{2, 1'b1, 1'b1, 0};
`ifdef OFMAP_DRAIN_RELU_EN
        rt[0] = '{32'hFFFF_FFFF, 32'h0000_0000};
        rt[1] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
        rt[2] = '{32'h8000_0000, 32'h0000_0000};
        rt[3] = '{32'h0000_0005, 32'h0000_0005};
`else
        rt[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        rt[1] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
        rt[2] = '{32'h8000_0000, 32'h8000_0000};
        rt[3] = '{32'h0000_0005, 32'h0000_0005};
`endif

        rstn = 1'b0; start_in = 1'b0; m_ready_in = 1'b0;
        #12;
        check("rst_busy", busy_out, 0);
        check("rst_valid", m_valid_out, 0);
        check("rst_rd_en", rd_en_out, 0);
        check("rst_addr", rd_addr_out, 0);
        check("rst_data", m_data_out, 0);
        check("rst_done", done_out, 0);
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            fill_mem(sc[i].rnd);
            build_exp();
            run_drain(sc[i].mode, sc[i].mid_start, sc[i].exp_cycles);
        end

        // Table-driven ReLU vectors in row 0; other rows random
        fill_mem(1'b1);
        for (int l = 0; l < MC; l++) mem[0][l] = rt[l].raw;
        build_exp();
        for (int l = 0; l < MC; l++) exp_q[l] = rt[l].expect_out;
        run_drain(0, 1'b0, NUM*(MC+2)+1);

        // Reset during row 2 lane 1 aborts, then a fresh start drains from row 0
        fill_mem(1'b0);
        @(negedge clk); start_in = 1'b1; m_ready_in = 1'b1;
        @(negedge clk); start_in = 1'b0;
        repeat (15) @(negedge clk);
        check("pre_reset_valid", m_valid_out, 1);
        check("pre_reset_word", m_data_out, ref_word(mem[2][1]));
        rstn = 1'b0;
        #1;
        check("abort_busy", busy_out, 0);
        check("abort_valid", m_valid_out, 0);
        check("abort_last", m_last_out, 0);
        check("abort_data", m_data_out, 0);
        check("abort_addr", rd_addr_out, 0);
        check("abort_rd_en", rd_en_out, 0);
        check("abort_done", done_out, 0);
        @(negedge clk); rstn = 1'b1; m_ready_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_abort_done", done_out, 0);
            check("post_abort_busy", busy_out, 0);
        end
        build_exp();
        run_drain(0, 1'b0, NUM*(MC+2)+1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
